// File: rtl/cla_pipe_adder_pkg.sv
// ---------------------------------------------------------------------------
// cla_pipe_adder_pkg
//   Shared definitions for the pipelined carry-lookahead adder/subtractor:
//   the CLA group width, the stage-count helper and the packed flag record
//   that the last pipeline stage registers next to the result.
// ---------------------------------------------------------------------------
package cla_pipe_adder_pkg;

    // Bits resolved by one carry-lookahead group.
    localparam int CLA_GRP_W = 4;

    // Result flags, registered together in the final stage.
    typedef struct packed {
        logic zero;
        logic ovf;
        logic cout;
    } cla_flags_t;

    // Number of pipeline stages for a given width and groups-per-stage.
    function automatic int cla_stages(input int width, input int gps);
        return width / (CLA_GRP_W * gps);
    endfunction

endpackage

// File: rtl/cla_pipe_adder_cla4_group.sv
// ---------------------------------------------------------------------------
// cla4_group
//   Purely combinational 4-bit carry-lookahead adder group.
//   Ports:
//     a, b   in   4   operand bits of this group
//     cin    in   1   carry into bit 0 of the group
//     s      out  4   sum bits
//     cout   out  1   carry out of bit 3
//     p_grp  out  1   group propagate (all four bits propagate)
//     g_grp  out  1   group generate (group produces a carry on its own)
//   The group P/G pair lets the enclosing stage chain several groups with
//   lookahead instead of rippling through every bit.
// ---------------------------------------------------------------------------
module cla4_group
    import cla_pipe_adder_pkg::*;
(
    input  logic [CLA_GRP_W-1:0] a,
    input  logic [CLA_GRP_W-1:0] b,
    input  logic                 cin,
    output logic [CLA_GRP_W-1:0] s,
    output logic                 cout,
    output logic                 p_grp,
    output logic                 g_grp
);

    logic [CLA_GRP_W-1:0] gen;
    logic [CLA_GRP_W-1:0] prop;
    logic [CLA_GRP_W-1:0] carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Every internal carry is a flat two-level expression of the bit
    // generate/propagate terms, so no carry depends on a lower carry.
    assign carry[0] = cin;
    assign carry[1] = gen[0] | (prop[0] & cin);
    assign carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin);
    assign carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                    | (prop[2] & prop[1] & prop[0] & cin);

    assign p_grp = &prop;
    assign g_grp = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                 | (prop[3] & prop[2] & prop[1] & gen[0]);

    assign s    = prop ^ carry;
    assign cout = g_grp | (p_grp & cin);

endmodule

// File: rtl/cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// cla_pipe_adder
//   Pipelined carry-lookahead adder/subtractor. The operands are cut into
//   slices of 4*GPS bits; stage k resolves slice k with the carry handed over
//   by stage k-1 and registers the growing result, the carry out of the slice
//   and the still-unresolved upper operand bits. The whole pipe advances as
//   one unit under a valid/ready handshake, giving one result per cycle.
//   Parameters:
//     WIDTH  operand/result width, a multiple of 4*GPS
//     GPS    4-bit CLA groups resolved per stage (STAGES = WIDTH/(4*GPS))
//   Ports:
//     clk        in   1      clock, rising edge
//     rst        in   1      synchronous active-high reset
//     in_valid   in   1      operands valid
//     in_ready   out  1      operands accepted this cycle
//     a, b       in   WIDTH  operands
//     cin        in   1      carry-in, add mode only
//     sub        in   1      1 selects a - b
//     out_valid  out  1      result valid
//     out_ready  in   1      consumer takes the result
//     y          out  WIDTH  sum/difference modulo 2^WIDTH
//     cout       out  1      carry out of the MSB (sub: 1 means no borrow)
//     ovf        out  1      two's-complement overflow
//     zero       out  1      y == 0
// ---------------------------------------------------------------------------
module cla_pipe_adder
    import cla_pipe_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GPS   = 1
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SW     = CLA_GRP_W * GPS;
    localparam int STAGES = cla_stages(WIDTH, GPS);

    if ((WIDTH % SW) != 0 || WIDTH < CLA_GRP_W) begin : g_param_check
        $error("cla_pipe_adder: WIDTH must be >= 4 and a multiple of 4*GPS");
    end

    logic             adv;
    logic [WIDTH-1:0] bx;
    logic             c0;

    // The pipe only moves when the output slot is empty or being drained,
    // so a stalled consumer freezes every stage at once (no bubble collapse).
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Subtraction is a + ~b + 1; the carry-in port is ignored in that mode.
    assign bx = sub ? ~b : b;
    assign c0 = sub ? 1'b1 : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int RES_W = SW * (k + 1);
        localparam int REM_W = WIDTH - SW * (k + 1);

        logic [SW-1:0]    op_a;
        logic [SW-1:0]    op_b;
        logic [SW-1:0]    s;
        logic             c_in;
        logic             v_in;
        logic [RES_W-1:0] y_in;
        logic [GPS:0]     c;
        logic [GPS-1:0]   grp_p;
        logic [GPS-1:0]   grp_g;
        logic [GPS-1:0]   grp_co;
        logic             v_r;
        logic [RES_W-1:0] y_r;

        // Stage 0 works straight off the conditioned inputs; later stages
        // take the lowest unresolved slice from the previous skew registers
        // and append their sum bits above the already-finished low bits.
        if (k == 0) begin : g_src
            assign op_a = a[SW-1:0];
            assign op_b = bx[SW-1:0];
            assign c_in = c0;
            assign v_in = in_valid;
            assign y_in = s;
        end else begin : g_src
            assign op_a = g_stage[k-1].g_fwd.a_r[SW-1:0];
            assign op_b = g_stage[k-1].g_fwd.bx_r[SW-1:0];
            assign c_in = g_stage[k-1].g_fwd.c_r;
            assign v_in = g_stage[k-1].v_r;
            assign y_in = {s, g_stage[k-1].y_r};
        end

        // Groups inside a stage chain through their P/G pair, so the carry
        // into each group is one AND-OR away from the previous one.
        assign c[0] = c_in;
        for (genvar gi = 0; gi < GPS; gi++) begin : g_grp
            cla4_group u_grp (
                .a     (op_a[CLA_GRP_W*gi +: CLA_GRP_W]),
                .b     (op_b[CLA_GRP_W*gi +: CLA_GRP_W]),
                .cin   (c[gi]),
                .s     (s[CLA_GRP_W*gi +: CLA_GRP_W]),
                .cout  (grp_co[gi]),
                .p_grp (grp_p[gi]),
                .g_grp (grp_g[gi])
            );
            assign c[gi+1] = grp_g[gi] | (grp_p[gi] & c[gi]);
        end

        // The lookahead carries and the groups' own carry-outs are two
        // routes to the same value; any difference is a broken group.
        always_comb begin
            assert (grp_co == c[GPS:1]);
        end

        // Valid and the finished low bits of the result travel together.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_r <= 1'b0;
                y_r <= '0;
            end else if (adv) begin
                v_r <= v_in;
                y_r <= y_in;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [REM_W-1:0] a_r;
            logic [REM_W-1:0] bx_r;
            logic [REM_W-1:0] a_in;
            logic [REM_W-1:0] bx_in;
            logic             c_r;

            if (k == 0) begin : g_hi
                assign a_in  = a[WIDTH-1:SW];
                assign bx_in = bx[WIDTH-1:SW];
            end else begin : g_hi
                assign a_in  = g_stage[k-1].g_fwd.a_r[REM_W+SW-1:SW];
                assign bx_in = g_stage[k-1].g_fwd.bx_r[REM_W+SW-1:SW];
            end

            // Skew registers: only the operand bits no stage has used yet.
            // Their content is irrelevant while the stage holds a bubble.
            always_ff @(posedge clk) begin
                if (adv) begin
                    a_r  <= a_in;
                    bx_r <= bx_in;
                end
            end

            // Carry handed to the next stage.
            always_ff @(posedge clk) begin
                if (rst) begin
                    c_r <= 1'b0;
                end else if (adv) begin
                    c_r <= c[GPS];
                end
            end
        end else begin : g_last
            cla_flags_t flags_r;
            logic       c_msb;

            // The sum bit is a ^ b ^ carry_in, so the carry into the MSB
            // falls out of the top operand bits and the top sum bit.
            assign c_msb = op_a[SW-1] ^ op_b[SW-1] ^ s[SW-1];

            // Flags are formed from the complete result and registered in
            // the same cycle as the last slice of y.
            always_ff @(posedge clk) begin
                if (rst) begin
                    flags_r <= '0;
                end else if (adv) begin
                    flags_r.cout <= c[GPS];
                    flags_r.ovf  <= c[GPS] ^ c_msb;
                    flags_r.zero <= (y_in == '0);
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_r;
    assign y         = g_stage[STAGES-1].y_r;
    assign cout      = g_stage[STAGES-1].g_last.flags_r.cout;
    assign ovf       = g_stage[STAGES-1].g_last.flags_r.ovf;
    assign zero      = g_stage[STAGES-1].g_last.flags_r.zero;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_cla_pipe_adder
//   Directed bench for the 16-bit, one-group-per-stage adder: a table of
//   hand-computed vectors applied one at a time, a back-to-back stream with
//   a consumer stall, and a reset with operations in flight.
// ---------------------------------------------------------------------------
module tb_cla_pipe_adder;

    localparam int WIDTH   = 16;
    localparam int GPS     = 1;
    localparam int LATENCY = 4;
    localparam int NVEC    = 14;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             cout;
    logic             ovf;
    logic             zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] y;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    typedef struct {
        logic [15:0] y;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    vec_t vecs [NVEC];
    res_t expq [$];

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(WIDTH), .GPS(GPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    // Compare one value and report it on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference: 17-bit sum for the carry; overflow when both addends share
    // a sign and the result sign differs from it.
    function automatic res_t refModel(input logic [15:0] ra, input logic [15:0] rb,
                                      input logic rcin, input logic rsub);
        res_t        r;
        logic [15:0] bb;
        logic [16:0] full;
        bb     = rsub ? ~rb : rb;
        full   = {1'b0, ra} + {1'b0, bb} + {16'd0, (rsub ? 1'b1 : rcin)};
        r.y    = full[15:0];
        r.cout = full[16];
        r.ovf  = (ra[15] == bb[15]) && (full[15] != ra[15]);
        r.zero = (full[15:0] == 16'd0);
        return r;
    endfunction

    // Present one operation and hold it until it is accepted; returns #1
    // after the accepting edge with in_valid dropped.
    task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb,
                                 input logic vcin, input logic vsub);
        int guard;
        guard    = 0;
        a        = va;
        b        = vb;
        cin      = vcin;
        sub      = vsub;
        in_valid = 1'b1;
        while (!in_ready && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("accept_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges (accepting edge = 1) until out_valid shows, bounded.
    task automatic waitResult(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Eight random operations issued back to back with a three-cycle
    // consumer stall in the middle; results are matched in order.
    task automatic runStream();
        int got;
        got = 0;
        fork
            begin
                logic [15:0] ra;
                logic [15:0] rb;
                logic        rc;
                logic        rs;
                int          guard;
                for (int i = 0; i < 8; i++) begin
                    ra = 16'($urandom);
                    rb = 16'($urandom);
                    rc = 1'($urandom_range(0, 1));
                    rs = 1'($urandom_range(0, 1));
                    a = ra; b = rb; cin = rc; sub = rs;
                    in_valid = 1'b1;
                    guard = 0;
                    do begin
                        @(negedge clk);
                        guard++;
                    end while (!in_ready && guard < 20);
                    expq.push_back(refModel(ra, rb, rc, rs));
                    @(posedge clk);
                    #1;
                end
                in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
            begin
                logic [15:0] held_y;
                logic        held;
                res_t        e;
                held = 1'b0;
                held_y = '0;
                for (int cyc = 0; cyc < 40; cyc++) begin
                    @(negedge clk);
                    if (out_valid && !out_ready) begin
                        checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
                        if (held) checkOutput("stall_hold_y", 32'(y), 32'(held_y));
                        held   = 1'b1;
                        held_y = y;
                    end else begin
                        held = 1'b0;
                    end
                    if (out_valid && out_ready) begin
                        if (expq.size() == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL stream_extra: got y=0x%0h, expected no result", y);
                        end else begin
                            e = expq.pop_front();
                            checkOutput($sformatf("stream%0d_y", got), 32'(y), 32'(e.y));
                            checkOutput($sformatf("stream%0d_cout", got), 32'(cout), 32'(e.cout));
                            checkOutput($sformatf("stream%0d_ovf", got), 32'(ovf), 32'(e.ovf));
                            checkOutput($sformatf("stream%0d_zero", got), 32'(zero), 32'(e.zero));
                            got++;
                        end
                    end
                end
            end
        join
        checkOutput("stream_count", 32'(got), 32'd8);
    endtask

    initial begin
        int lat;
        int seen;

        //        a         b         cin   sub   y         cout  ovf   zero
        vecs[0]  = '{16'h0003, 16'h0002, 1'b1, 1'b0, 16'h0006, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{16'h000F, 16'h000F, 1'b1, 1'b0, 16'h001F, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_y", 32'(y), 32'd0);
        checkOutput("rst_flags", {29'd0, zero, ovf, cout}, 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

        $display("[TB] directed vectors");
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            waitResult(lat);
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(LATENCY));
            checkOutput($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].y));
            checkOutput($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].cout));
            checkOutput($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
            checkOutput($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].zero));
            @(posedge clk);
            #1;
        end

        $display("[TB] back-to-back stream with consumer stall");
        runStream();
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] reset with operations in flight");
        applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0);
        applyStimulus(16'h0002, 16'h0002, 1'b0, 1'b0);
        applyStimulus(16'h0003, 16'h0003, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_y", 32'(y), 32'd0);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) seen++;
            @(posedge clk);
            #1;
        end
        checkOutput("flush_no_results", 32'(seen), 32'd0);
        applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0);
        waitResult(lat);
        checkOutput("post_rst_latency", 32'(lat), 32'(LATENCY));
        checkOutput("post_rst_y", 32'(y), 32'h3333);
        checkOutput("post_rst_flags", {29'd0, zero, ovf, cout}, 32'd0);
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
